// File: rtl/dtc_pkg.sv
// ---------------------------------------------------------------------------
// dtc_pkg
// Shared definitions for the dtc_* decision-tree classifier family.
//   DTC_N_CLS    : number of thermometer bits (classes 0..DTC_N_CLS)
//   DTC_IDX_W    : width of a binary class index
//   dtc_therm_t  : thermometer-coded class value
//   dtc_idx_t    : binary class index
//   therm_legal(): 1 when a code has the form 0..01..1 (ones packed from bit 0)
// ---------------------------------------------------------------------------
package dtc_pkg;

    localparam int DTC_N_CLS = 9;
    localparam int DTC_IDX_W = 4;

    typedef logic [DTC_N_CLS-1:0] dtc_therm_t;
    typedef logic [DTC_IDX_W-1:0] dtc_idx_t;

    // A legal code 2^k-1 has no zero below its top one, so adding 1 carries
    // through every one and the AND with the original is empty. The all-ones
    // code wraps to zero, which gives the same answer.
    function automatic logic therm_legal(input dtc_therm_t code);
        return ((code & (code + dtc_therm_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/dtc_sat_cnt.sv
// ---------------------------------------------------------------------------
// dtc_sat_cnt
// Saturating up-counter with a synchronous clear that takes priority over
// increment.
//   clk : clock
//   rst : synchronous active-high reset
//   inc : count one event this cycle (ignored once at all-ones)
//   clr : zero the counter on the next edge, winning over inc
//   cnt : current count
// ---------------------------------------------------------------------------
module dtc_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: flop state uses non-blocking assignments so every always_ff
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/dtc_therm_dec.sv
// ---------------------------------------------------------------------------
// dtc_therm_dec
// Two-stage streaming decoder: thermometer code in, binary class index out,
// with a bubble flag and saturating statistics.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake
//   in_code              : thermometer code (ones packed from bit 0)
//   out_valid/out_ready  : output handshake
//   out_idx              : popcount of the code
//   out_err              : code was not of the form 2^k-1
//   err_cnt              : saturating count of delivered results with out_err
//   stat_clr             : synchronous clear of all statistics counters
//   hist_sel, hist_cnt   : registered read of one per-class bin
//                          (only when DTC_THERM_HIST_EN is defined)
// Build option: define DTC_THERM_HIST_EN to add the per-class histogram.
// ---------------------------------------------------------------------------
module dtc_therm_dec
    import dtc_pkg::*;
#(
    parameter int N_CLS = DTC_N_CLS,
    parameter int CNT_W = 16,
    parameter int IDX_W = $clog2(N_CLS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_CLS-1:0] in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             stat_clr
`ifdef DTC_THERM_HIST_EN
    ,
    input  logic [IDX_W-1:0] hist_sel,
    output logic [CNT_W-1:0] hist_cnt
`endif
);

    // Stage 1: raw code
    logic             r_s1_valid;
    logic [N_CLS-1:0] r_s1_code;
    // Stage 2: decoded result
    logic             r_s2_valid;
    logic [IDX_W-1:0] r_s2_idx;
    logic             r_s2_err;

    logic             w_s1_move;
    logic             w_out_fire;
    logic [IDX_W-1:0] w_pop;
    logic             w_legal;

    // S2 can take a new value when it is empty or being drained this cycle;
    // S1 can then pass its value on, so it is free too. out_ready -> in_ready
    // is the only combinational path through the block.
    assign w_s1_move  = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s1_move;
    assign w_out_fire = r_s2_valid && out_ready;

    // NOTE: every variable written here gets a default before the loop, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_CLS; i++) begin
            w_pop = w_pop + IDX_W'(r_s1_code[i]);
        end
    end

    if (N_CLS == DTC_N_CLS) begin : g_legal_pkg
        assign w_legal = therm_legal(r_s1_code);
    end else begin : g_legal_gen
        assign w_legal = ((r_s1_code & (r_s1_code + N_CLS'(1))) == '0);
    end

    // NOTE: the data registers are reset along with the valid bits; there
    // are only a few of them and out_idx/out_err then read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_code <= in_code;
            end
        end
    end

    // S2 only moves when w_s1_move is set, which holds the result stable
    // while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_idx   <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s1_move) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_idx <= w_pop;
                r_s2_err <= !w_legal;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_idx   = r_s2_idx;
    assign out_err   = r_s2_err;

    dtc_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_out_fire && r_s2_err),
        .clr (stat_clr),
        .cnt (err_cnt)
    );

`ifdef DTC_THERM_HIST_EN
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N_CLS);

    logic [CNT_W-1:0] w_bin [N_CLS+1];
    logic [CNT_W-1:0] r_hist_cnt;

    for (genvar k = 0; k <= N_CLS; k++) begin : g_bin
        dtc_sat_cnt #(.W(CNT_W)) u_bin (
            .clk (clk),
            .rst (rst),
            .inc (w_out_fire && (r_s2_idx == IDX_W'(k))),
            .clr (stat_clr),
            .cnt (w_bin[k])
        );
    end

    // Out-of-range selects read as zero rather than indexing past the bins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist_cnt <= '0;
        end else if (hist_sel > MAX_IDX) begin
            r_hist_cnt <= '0;
        end else begin
            r_hist_cnt <= w_bin[hist_sel];
        end
    end

    assign hist_cnt = r_hist_cnt;
`endif

endmodule

// File: tb/tb_dtc_therm_dec.sv
// ---------------------------------------------------------------------------
// tb_dtc_therm_dec
// Self-checking bench for dtc_therm_dec. Two instances share all inputs: one
// with the default 16-bit counters and one with 2-bit counters so that
// saturation is reachable. A reference model (queue of in-flight codes plus
// plain counters) is evaluated every falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dtc_therm_dec;
    import dtc_pkg::*;

    localparam int N_CLS     = DTC_N_CLS;
    localparam int IDX_W     = DTC_IDX_W;
    localparam int CNT_W     = 16;
    localparam int CNT_W_SAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [N_CLS-1:0] in_code;
    logic             out_ready;
    logic             stat_clr;

    logic                 in_ready,  s_in_ready;
    logic                 out_valid, s_out_valid;
    logic [IDX_W-1:0]     out_idx,   s_out_idx;
    logic                 out_err,   s_out_err;
    logic [CNT_W-1:0]     err_cnt;
    logic [CNT_W_SAT-1:0] s_err_cnt;
`ifdef DTC_THERM_HIST_EN
    logic [IDX_W-1:0]     hist_sel;
    logic [CNT_W-1:0]     hist_cnt;
    logic [CNT_W_SAT-1:0] s_hist_cnt;
`endif

    always #5 clk = ~clk;

    dtc_therm_dec #(.N_CLS(N_CLS), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_err   (out_err),
        .err_cnt   (err_cnt),
        .stat_clr  (stat_clr)
`ifdef DTC_THERM_HIST_EN
        ,
        .hist_sel  (hist_sel),
        .hist_cnt  (hist_cnt)
`endif
    );

    dtc_therm_dec #(.N_CLS(N_CLS), .CNT_W(CNT_W_SAT)) u_dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_code   (in_code),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_idx   (s_out_idx),
        .out_err   (s_out_err),
        .err_cnt   (s_err_cnt),
        .stat_clr  (stat_clr)
`ifdef DTC_THERM_HIST_EN
        ,
        .hist_sel  (hist_sel),
        .hist_cnt  (s_hist_cnt)
`endif
    );

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    typedef struct {
        int          idx;
        bit          err;
        int unsigned cyc;
    } item_t;

    item_t       q[$];
    int unsigned cyc = 0;
    int unsigned err_m[2];
    int unsigned hist_m[2][N_CLS+1];
    int unsigned hist_exp[2];
    int unsigned max_m[2] = '{(1 << CNT_W) - 1, (1 << CNT_W_SAT) - 1};
    bit          exp_valid;
    bit          exp_ready;

    function automatic int ref_idx(input logic [N_CLS-1:0] c);
        return $countones(c);
    endfunction

    // Illegal unless the code equals 2^k-1 for some k in 0..N_CLS.
    function automatic bit ref_err(input logic [N_CLS-1:0] c);
        for (int k = 0; k <= N_CLS; k++) begin
            if (int'(c) == (1 << k) - 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            err_m[d] = 0;
            for (int k = 0; k <= N_CLS; k++) hist_m[d][k] = 0;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            clear_stats();
            hist_exp = '{0, 0};
        end else begin
            // An item accepted in cycle c is at the output from cycle c+2.
            exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
            exp_ready = (q.size() < 2) || out_ready;
            check("in_ready",      in_ready,    exp_ready);
            check("sat_in_ready",  s_in_ready,  exp_ready);
            check("out_valid",     out_valid,   exp_valid);
            check("sat_out_valid", s_out_valid, exp_valid);
            if (exp_valid) begin
                check("out_idx",     out_idx,   q[0].idx);
                check("out_err",     out_err,   q[0].err);
                check("sat_out_idx", s_out_idx, q[0].idx);
            end
            check("err_cnt",     err_cnt,   err_m[0]);
            check("sat_err_cnt", s_err_cnt, err_m[1]);
`ifdef DTC_THERM_HIST_EN
            check("hist_cnt",     hist_cnt,   hist_exp[0]);
            check("sat_hist_cnt", s_hist_cnt, hist_exp[1]);
            for (int d = 0; d < 2; d++) begin
                hist_exp[d] = (int'(hist_sel) <= N_CLS) ? hist_m[d][hist_sel] : 0;
            end
`endif
            // Effects of this cycle's handshakes at the coming edge.
            if (stat_clr) begin
                clear_stats();
            end else if (exp_valid && out_ready) begin
                for (int d = 0; d < 2; d++) begin
                    if (q[0].err && err_m[d] < max_m[d]) err_m[d]++;
                    if (hist_m[d][q[0].idx] < max_m[d]) hist_m[d][q[0].idx]++;
                end
            end
            if (exp_valid && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) begin
                q.push_back('{idx: ref_idx(in_code), err: ref_err(in_code), cyc: cyc});
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N_CLS-1:0] code);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_code  = code;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        check("send_handshake", done, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    localparam logic [N_CLS-1:0] BUBBLE = 9'b000101111;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got 0, expected 1");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
        stat_clr  = 1'b0;
`ifdef DTC_THERM_HIST_EN
        hist_sel  = '0;
`endif
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_idx",   out_idx,   0);
        check("rst_out_err",   out_err,   1'b0);
        check("rst_err_cnt",   err_cnt,   0);
        check("rst_in_ready",  in_ready,  1'b1);
        tick();

        // Legal sweep, back to back
        for (int k = 0; k <= N_CLS; k++) send(N_CLS'((1 << k) - 1));
        idle(4);
        @(negedge clk);
        check("sweep_err_cnt", err_cnt, 0);
        tick();

        // Single bubbled code
        send(BUBBLE);
        idle(3);
        @(negedge clk);
        check("bubble_err_cnt",     err_cnt,   1);
        check("bubble_sat_err_cnt", s_err_cnt, 1);
        tick();

        // Back-pressure: two codes fill the pipe, then in_ready drops
        out_ready = 1'b0;
        send(9'h003);
        send(9'h007);
        in_valid = 1'b1;
        in_code  = 9'h00f;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready",  in_ready,  1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_idx",   out_idx,   2);
            tick();
        end
        out_ready = 1'b1;
        send(9'h00f);
        send(9'h1ff);
        send(BUBBLE);
        send(9'h000);
        idle(4);

        // Saturation on the 2-bit instance, then clear colliding with an event
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        repeat (5) send(BUBBLE);
        idle(4);
        @(negedge clk);
        check("sat_err_cnt_3", s_err_cnt, 3);
        check("wide_err_cnt_5", err_cnt,  5);
        tick();
        send(BUBBLE);
        tick();
        stat_clr = 1'b1;
        @(negedge clk);
        check("clr_hs_valid", out_valid, 1'b1);
        check("clr_hs_err",   out_err,   1'b1);
        tick();
        stat_clr = 1'b0;
        @(negedge clk);
        check("clr_sat_err_cnt",  s_err_cnt, 0);
        check("clr_wide_err_cnt", err_cnt,   0);
        tick();

        // Reset with both stages full
        out_ready = 1'b0;
        send(9'h001);
        send(BUBBLE);
        @(negedge clk);
        check("full_out_valid", out_valid, 1'b1);
        tick();
        pulse_reset();
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready",  in_ready,  1'b1);
        tick();
        out_ready = 1'b1;
        idle(4);

`ifdef DTC_THERM_HIST_EN
        // Histogram read-back
        pulse_reset();
        repeat (3) send(9'h07f);
        send(9'h000);
        idle(4);
        hist_sel = 4'd7;
        tick();
        @(negedge clk);
        check("hist_bin7", hist_cnt, 3);
        tick();
        hist_sel = 4'd12;
        tick();
        @(negedge clk);
        check("hist_sel12", hist_cnt, 0);
        tick();
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                in_code = N_CLS'((1 << $urandom_range(0, N_CLS)) - 1);
            end else begin
                in_code = N_CLS'($urandom);
            end
            out_ready = (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            stat_clr  = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 499) == 0);
`ifdef DTC_THERM_HIST_EN
            hist_sel  = IDX_W'($urandom);
`endif
            tick();
        end
        rst       = 1'b0;
        stat_clr  = 1'b0;
        out_ready = 1'b1;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
